// File: rtl/jtgng_rom_fetch_if.sv
// SDRAM read-port bundle between the ROM fetcher (master) and the SDRAM controller (slave).
// Latency: none, wires only.
// Backpressure: read_req is held until sdram_ack; data_rdy has no backpressure.
interface jtgng_rom_fetch_if;
  logic        read_req;
  logic [21:0] sdram_addr;
  logic        sdram_ack;
  logic        data_rdy;
  logic [31:0] data_read;
  logic        refresh_en;

  modport master (
    output read_req, sdram_addr, refresh_en,
    input  sdram_ack, data_rdy, data_read
  );

  modport slave (
    input  read_req, sdram_addr, refresh_en,
    output sdram_ack, data_rdy, data_read
  );
endinterface

// File: rtl/jtgng_rom_fetch.sv
// Three-slot ROM fetcher: per-slot one-word tagged cache, misses arbitrated onto one SDRAM read port.
// Latency: hit -> ok in 1 cycle; miss -> ok in 1 + ack wait + data wait + 2 cycles.
// Backpressure: read_req held until sdram_ack; one request outstanding; refresh only when nothing pends.
module jtgng_rom_fetch #(
  parameter int          AW           = 17,
  parameter logic [21:0] SLOT0_OFFSET = 22'h00_0000,
  parameter logic [21:0] SLOT1_OFFSET = 22'h08_0000,
  parameter logic [21:0] SLOT2_OFFSET = 22'h10_0000,
  parameter int          TIMEOUT      = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              downloading,
  input  logic              slot0_cs,
  input  logic [AW-1:0]     slot0_addr,
  output logic [31:0]       slot0_dout,
  output logic              slot0_ok,
  input  logic              slot1_cs,
  input  logic [AW-1:0]     slot1_addr,
  output logic [31:0]       slot1_dout,
  output logic              slot1_ok,
  input  logic              slot2_cs,
  input  logic [AW-1:0]     slot2_addr,
  output logic [31:0]       slot2_dout,
  output logic              slot2_ok,
  jtgng_rom_fetch_if.master sdram
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, FILL} state_t;

  state_t state, state_nxt;

  logic [2:0]    cs;
  logic [AW-1:0] addr [3];
  logic [2:0]    hit;
  logic [2:0]    miss;
  logic [2:0]    ok_q;

  logic [2:0]    valid;
  logic [AW-1:0] tag  [3];
  logic [31:0]   data [3];

  logic [1:0]    win_idx;
  logic [21:0]   win_base;
  logic [AW-1:0] win_addr;

  logic          read_req_q, req_nxt;
  logic [21:0]   sdram_addr_q, addr_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [1:0]    req_idx, idx_nxt;
  logic [AW-1:0] req_tag, tag_nxt;
  logic          fill_go;
  logic          refresh_q;

  assign cs      = {slot2_cs, slot1_cs, slot0_cs};
  assign addr[0] = slot0_addr;
  assign addr[1] = slot1_addr;
  assign addr[2] = slot2_addr;

  // Hit/miss per slot; a hit always compares against the pre-fill cache contents.
  always_comb begin
    hit  = '0;
    miss = '0;
    for (int i = 0; i < 3; i++) begin
      hit[i]  = cs[i] & valid[i] & (tag[i] == addr[i]);
      miss[i] = cs[i] & ~hit[i] & ~downloading;
    end
  end

  // Fixed priority slot0 > slot1 > slot2, picks the miss to request.
  always_comb begin
    win_idx  = 2'd0;
    win_base = SLOT0_OFFSET;
    win_addr = slot0_addr;
    if (miss[0]) begin
      win_idx  = 2'd0;
      win_base = SLOT0_OFFSET;
      win_addr = slot0_addr;
    end else if (miss[1]) begin
      win_idx  = 2'd1;
      win_base = SLOT1_OFFSET;
      win_addr = slot1_addr;
    end else if (miss[2]) begin
      win_idx  = 2'd2;
      win_base = SLOT2_OFFSET;
      win_addr = slot2_addr;
    end
  end

  // Next-state and request-register logic; downloading aborts everything back to IDLE.
  always_comb begin
    state_nxt = state;
    req_nxt   = read_req_q;
    addr_nxt  = sdram_addr_q;
    cnt_nxt   = cnt;
    idx_nxt   = req_idx;
    tag_nxt   = req_tag;
    fill_go   = 1'b0;
    if (downloading) begin
      state_nxt = IDLE;
      req_nxt   = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|miss) begin
            idx_nxt   = win_idx;
            tag_nxt   = win_addr;
            addr_nxt  = win_base + 22'(win_addr);
            req_nxt   = 1'b1;
            state_nxt = REQ;
          end
        end
        REQ: begin
          if (sdram.sdram_ack) begin
            req_nxt   = 1'b0;
            cnt_nxt   = '0;
            state_nxt = WAIT;
          end
        end
        WAIT: begin
          if (sdram.data_rdy) begin
            state_nxt = FILL;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            // Give up; the miss is still visible in IDLE and gets re-requested.
            state_nxt = IDLE;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        FILL: begin
          fill_go   = 1'b1;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Request tag, SDRAM request outputs, timeout counter and refresh permission.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      read_req_q   <= 1'b0;
      sdram_addr_q <= '0;
      cnt          <= '0;
      req_idx      <= '0;
      req_tag      <= '0;
      refresh_q    <= 1'b0;
    end else begin
      read_req_q   <= req_nxt;
      sdram_addr_q <= addr_nxt;
      cnt          <= cnt_nxt;
      req_idx      <= idx_nxt;
      req_tag      <= tag_nxt;
      refresh_q    <= (state == IDLE) & ~|miss & ~downloading;
    end
  end

  // Cache fill from the latched tag, flush on download, registered ok flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
      ok_q  <= '0;
      for (int i = 0; i < 3; i++) begin
        tag[i]  <= '0;
        data[i] <= '0;
      end
    end else begin
      ok_q <= hit & {3{~downloading}};
      for (int i = 0; i < 3; i++) begin
        if (downloading) begin
          valid[i] <= 1'b0;
        end else if (fill_go && (req_idx == 2'(i))) begin
          valid[i] <= 1'b1;
          tag[i]   <= req_tag;
          data[i]  <= sdram.data_read;
        end
      end
    end
  end

  assign sdram.read_req   = read_req_q;
  assign sdram.sdram_addr = sdram_addr_q;
  assign sdram.refresh_en = refresh_q;

  assign slot0_ok   = ok_q[0];
  assign slot1_ok   = ok_q[1];
  assign slot2_ok   = ok_q[2];
  assign slot0_dout = data[0];
  assign slot1_dout = data[1];
  assign slot2_dout = data[2];

endmodule

// File: tb/tb_jtgng_rom_fetch.sv
// Bench for jtgng_rom_fetch: SDRAM controller model plus a slot-level cache model.
// Latency: n/a.
// Backpressure: controller model acks after a configurable or random delay.
module tb_jtgng_rom_fetch;
  localparam int AW      = 17;
  localparam int TIMEOUT = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          downloading = 1'b0;
  logic [2:0]    cs = '0;
  logic [AW-1:0] addr [3];
  logic [31:0]   dout [3];
  logic [2:0]    ok;

  jtgng_rom_fetch_if sd();

  jtgng_rom_fetch #(.AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .downloading(downloading),
    .slot0_cs(cs[0]), .slot0_addr(addr[0]), .slot0_dout(dout[0]), .slot0_ok(ok[0]),
    .slot1_cs(cs[1]), .slot1_addr(addr[1]), .slot1_dout(dout[1]), .slot1_ok(ok[1]),
    .slot2_cs(cs[2]), .slot2_addr(addr[2]), .slot2_dout(dout[2]), .slot2_ok(ok[2]),
    .sdram(sd)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  // controller model controls and logs
  bit          ctrl_en = 1'b1;
  bit          rand_dly = 1'b0;
  bit          force_en = 1'b0;
  bit          busy = 1'b0;
  int          ack_dly = 2;
  int          rdy_dly = 3;
  logic [31:0] force_dat = '0;
  logic [21:0] req_log [$];
  logic [21:0] ack_log [$];
  int          ack_cnt = 0;
  int          done_cnt = 0;
  int          rdy_cyc = 0;

  // slot-level cache model: what each slot should currently hold
  bit          m_valid [3];
  logic [AW-1:0] m_tag [3];

  function automatic logic [21:0] base_of(input int i);
    case (i)
      0:       return 22'h000000;
      1:       return 22'h080000;
      default: return 22'h100000;
    endcase
  endfunction

  function automatic logic [21:0] sd_addr_of(input int i, input logic [AW-1:0] a);
    return base_of(i) + 22'(a);
  endfunction

  function automatic logic [31:0] mem_word(input logic [21:0] a);
    return ({10'd0, a} * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  // SDRAM controller model: serial, one request at a time
  initial begin : sdram_model
    logic [21:0] a;
    int ad, rd;
    forever begin
      @(posedge clk); #1;
      if (ctrl_en && sd.read_req === 1'b1) begin
        busy = 1'b1;
        a = sd.sdram_addr;
        req_log.push_back(a);
        ad = rand_dly ? int'($urandom_range(1, 4)) : ack_dly;
        rd = rand_dly ? int'($urandom_range(1, 6)) : rdy_dly;
        repeat (ad) @(posedge clk);
        #1 sd.sdram_ack = 1'b1;
        ack_log.push_back(sd.sdram_addr);
        @(posedge clk); #1 sd.sdram_ack = 1'b0;
        ack_cnt++;
        repeat (rd - 1) @(posedge clk);
        #1 sd.data_rdy = 1'b1;
        rdy_cyc = cyc + 1;
        @(posedge clk); #1 sd.data_rdy = 1'b0;
        sd.data_read = force_en ? force_dat : mem_word(a);
        @(posedge clk); #1 sd.data_read = $urandom;
        done_cnt++;
        busy = 1'b0;
      end
    end
  end

  task automatic wait_ok(input logic [2:0] mask, input int limit, output bit got);
    got = 1'b0;
    for (int n = 0; n < limit && !got; n++) begin
      @(posedge clk); #1;
      if ((ok & mask) == mask) got = 1'b1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (sd.read_req !== 1'b0) begin n_fail++; $display("FAIL reset_read_req got=%b exp=0", sd.read_req); end
    n_checks++; if (sd.sdram_addr !== 22'h0) begin n_fail++; $display("FAIL reset_sdram_addr got=%h exp=0", sd.sdram_addr); end
    n_checks++; if (sd.refresh_en !== 1'b0) begin n_fail++; $display("FAIL reset_refresh_en got=%b exp=0", sd.refresh_en); end
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (ok[i] !== 1'b0) begin n_fail++; $display("FAIL reset_ok%0d got=%b exp=0", i, ok[i]); end
      n_checks++; if (dout[i] !== 32'h0) begin n_fail++; $display("FAIL reset_dout%0d got=%h exp=0", i, dout[i]); end
    end
    rst = 1'b0;
  endtask

  task automatic test_single_miss;
    bit got;
    req_log.delete(); ack_log.delete();
    rand_dly = 1'b0; ack_dly = 2; rdy_dly = 3;
    force_en = 1'b1; force_dat = 32'hDEADBEEF;
    cs = 3'b001; addr[0] = 17'h00010;
    wait_ok(3'b001, 200, got);
    n_checks++; if (!got) begin n_fail++; $display("FAIL single_ok got=0 exp=1"); end
    n_checks++; if (req_log.size() != 1) begin n_fail++; $display("FAIL single_req_count got=%0d exp=1", req_log.size()); end
    if (req_log.size() >= 1) begin
      n_checks++; if (req_log[0] !== 22'h000010) begin n_fail++; $display("FAIL single_addr got=%h exp=000010", req_log[0]); end
    end
    if (ack_log.size() >= 1) begin
      n_checks++; if (ack_log[0] !== 22'h000010) begin n_fail++; $display("FAIL single_addr_at_ack got=%h exp=000010", ack_log[0]); end
    end
    n_checks++; if (dout[0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_dout got=%h exp=deadbeef", dout[0]); end
    n_checks++; if (cyc - rdy_cyc != 2) begin n_fail++; $display("FAIL single_rdy_to_ok got=%0d exp=2", cyc - rdy_cyc); end
    force_en = 1'b0;
  endtask

  task automatic test_repeated_hit;
    int n0;
    n0 = req_log.size();
    for (int n = 0; n < 100; n++) begin
      @(posedge clk); #1;
      n_checks++;
      if (ok[0] !== 1'b1 || sd.read_req !== 1'b0) begin
        n_fail++; $display("FAIL hold_hit cyc=%0d ok0=%b read_req=%b exp ok0=1 read_req=0", n, ok[0], sd.read_req);
      end
    end
    n_checks++; if (sd.refresh_en !== 1'b1) begin n_fail++; $display("FAIL hold_refresh got=%b exp=1", sd.refresh_en); end
    n_checks++; if (req_log.size() != n0) begin n_fail++; $display("FAIL hold_no_req got=%0d exp=%0d", req_log.size(), n0); end
  endtask

  task automatic test_priority;
    bit got;
    logic [21:0] exp_log [3];
    req_log.delete();
    ack_dly = 1; rdy_dly = 2;
    cs = 3'b111; addr[1] = 17'd5; addr[2] = 17'd7;
    for (int n = 0; n < 100 && req_log.size() == 0; n++) begin
      @(posedge clk); #1;
    end
    addr[0] = 17'h00020;
    wait_ok(3'b111, 400, got);
    exp_log[0] = 22'h080005; exp_log[1] = 22'h000020; exp_log[2] = 22'h100007;
    n_checks++; if (!got) begin n_fail++; $display("FAIL prio_ok got=%b exp=111", ok); end
    n_checks++; if (req_log.size() != 3) begin n_fail++; $display("FAIL prio_req_count got=%0d exp=3", req_log.size()); end
    for (int i = 0; i < 3 && i < req_log.size(); i++) begin
      n_checks++; if (req_log[i] !== exp_log[i]) begin n_fail++; $display("FAIL prio_order%0d got=%h exp=%h", i, req_log[i], exp_log[i]); end
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (dout[i] !== mem_word(sd_addr_of(i, addr[i]))) begin
        n_fail++; $display("FAIL prio_dout%0d got=%h exp=%h", i, dout[i], mem_word(sd_addr_of(i, addr[i])));
      end
    end
  endtask

  task automatic test_flush;
    bit got;
    n_checks++; if (ok !== 3'b111) begin n_fail++; $display("FAIL flush_pre_ok got=%b exp=111", ok); end
    req_log.delete();
    downloading = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (ok !== 3'b000) begin n_fail++; $display("FAIL flush_ok got=%b exp=000", ok); end
    n_checks++; if (sd.refresh_en !== 1'b0) begin n_fail++; $display("FAIL flush_refresh got=%b exp=0", sd.refresh_en); end
    for (int n = 0; n < 9; n++) begin
      @(posedge clk); #1;
      n_checks++;
      if (sd.read_req !== 1'b0 || sd.refresh_en !== 1'b0 || ok !== 3'b000) begin
        n_fail++; $display("FAIL flush_hold read_req=%b refresh=%b ok=%b exp 0 0 000", sd.read_req, sd.refresh_en, ok);
      end
    end
    downloading = 1'b0;
    wait_ok(3'b111, 400, got);
    n_checks++; if (!got) begin n_fail++; $display("FAIL flush_refill got=%b exp=111", ok); end
    n_checks++; if (req_log.size() != 3) begin n_fail++; $display("FAIL flush_req_count got=%0d exp=3", req_log.size()); end
    for (int i = 0; i < 3 && i < req_log.size(); i++) begin
      n_checks++;
      if (req_log[i] !== sd_addr_of(i, addr[i])) begin
        n_fail++; $display("FAIL flush_order%0d got=%h exp=%h", i, req_log[i], sd_addr_of(i, addr[i]));
      end
    end
  endtask

  task automatic test_addr_change;
    bit got;
    int a0, d0;
    cs = 3'b100; addr[2] = 17'd7;
    downloading = 1'b1;
    @(posedge clk); #1 downloading = 1'b0;
    req_log.delete();
    ack_dly = 2; rdy_dly = 6;
    a0 = ack_cnt; d0 = done_cnt;
    for (int n = 0; n < 100 && ack_cnt == a0; n++) begin
      @(posedge clk); #1;
    end
    addr[2] = 17'd8;
    for (int n = 0; n < 100 && done_cnt == d0; n++) begin
      @(posedge clk); #1;
    end
    n_checks++; if (dout[2] !== mem_word(22'h100007)) begin n_fail++; $display("FAIL chg_first_fill got=%h exp=%h", dout[2], mem_word(22'h100007)); end
    for (int n = 0; n < 3; n++) begin
      @(posedge clk); #1;
      n_checks++; if (ok[2] !== 1'b0) begin n_fail++; $display("FAIL chg_stale_ok got=%b exp=0", ok[2]); end
    end
    wait_ok(3'b100, 200, got);
    n_checks++; if (!got) begin n_fail++; $display("FAIL chg_ok got=0 exp=1"); end
    n_checks++; if (req_log.size() != 2) begin n_fail++; $display("FAIL chg_req_count got=%0d exp=2", req_log.size()); end
    if (req_log.size() >= 2) begin
      n_checks++; if (req_log[0] !== 22'h100007) begin n_fail++; $display("FAIL chg_req0 got=%h exp=100007", req_log[0]); end
      n_checks++; if (req_log[1] !== 22'h100008) begin n_fail++; $display("FAIL chg_req1 got=%h exp=100008", req_log[1]); end
    end
    n_checks++; if (dout[2] !== mem_word(22'h100008)) begin n_fail++; $display("FAIL chg_dout got=%h exp=%h", dout[2], mem_word(22'h100008)); end
  endtask

  task automatic test_timeout;
    bit got;
    int ack_cyc, rise_cyc;
    for (int n = 0; n < 100 && (busy || sd.read_req === 1'b1); n++) begin
      @(posedge clk); #1;
    end
    ctrl_en = 1'b0;
    req_log.delete();
    cs = 3'b010; addr[1] = 17'h1ABCD;
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(posedge clk); #1;
      if (sd.read_req === 1'b1) got = 1'b1;
    end
    n_checks++; if (!got) begin n_fail++; $display("FAIL to_first_req got=0 exp=1"); end
    n_checks++; if (sd.sdram_addr !== 22'h09ABCD) begin n_fail++; $display("FAIL to_addr got=%h exp=09abcd", sd.sdram_addr); end
    @(posedge clk); #1 sd.sdram_ack = 1'b1;
    ack_cyc = cyc + 1;
    @(posedge clk); #1 sd.sdram_ack = 1'b0;
    n_checks++; if (sd.refresh_en !== 1'b0) begin n_fail++; $display("FAIL to_refresh got=%b exp=0", sd.refresh_en); end
    got = 1'b0; rise_cyc = 0;
    for (int n = 0; n < 200 && !got; n++) begin
      @(posedge clk); #1;
      if (sd.read_req === 1'b1) begin got = 1'b1; rise_cyc = cyc; end
    end
    n_checks++; if (!got) begin n_fail++; $display("FAIL to_retry got=0 exp=1"); end
    n_checks++; if (rise_cyc - ack_cyc != TIMEOUT + 1) begin n_fail++; $display("FAIL to_retry_delay got=%0d exp=%0d", rise_cyc - ack_cyc, TIMEOUT + 1); end
    n_checks++; if (sd.sdram_addr !== 22'h09ABCD) begin n_fail++; $display("FAIL to_retry_addr got=%h exp=09abcd", sd.sdram_addr); end
    ctrl_en = 1'b1;
    wait_ok(3'b010, 200, got);
    n_checks++; if (!got) begin n_fail++; $display("FAIL to_ok got=0 exp=1"); end
    n_checks++; if (dout[1] !== mem_word(22'h09ABCD)) begin n_fail++; $display("FAIL to_dout got=%h exp=%h", dout[1], mem_word(22'h09ABCD)); end
  endtask

  task automatic test_random;
    bit got;
    logic [2:0] c;
    logic [AW-1:0] na [3];
    logic [21:0] exp_q [$];
    cs = 3'b000;
    downloading = 1'b1;
    @(posedge clk); #1 downloading = 1'b0;
    for (int i = 0; i < 3; i++) m_valid[i] = 1'b0;
    rand_dly = 1'b1;
    for (int r = 0; r < 25; r++) begin
      c = 3'($urandom_range(1, 7));
      exp_q.delete();
      for (int i = 0; i < 3; i++) begin
        na[i] = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom);
        if (c[i] && !(m_valid[i] && m_tag[i] == na[i])) begin
          exp_q.push_back(sd_addr_of(i, na[i]));
          m_valid[i] = 1'b1;
          m_tag[i] = na[i];
        end
      end
      req_log.delete();
      cs = c;
      for (int i = 0; i < 3; i++) addr[i] = na[i];
      @(posedge clk); #1;
      wait_ok(c, 2000, got);
      n_checks++; if (!got) begin n_fail++; $display("FAIL rnd_ok round=%0d got=%b exp_mask=%b", r, ok, c); end
      n_checks++;
      if (req_log.size() != exp_q.size()) begin
        n_fail++; $display("FAIL rnd_req_count round=%0d got=%0d exp=%0d", r, req_log.size(), exp_q.size());
      end
      for (int k = 0; k < exp_q.size() && k < req_log.size(); k++) begin
        n_checks++; if (req_log[k] !== exp_q[k]) begin n_fail++; $display("FAIL rnd_req round=%0d idx=%0d got=%h exp=%h", r, k, req_log[k], exp_q[k]); end
      end
      for (int i = 0; i < 3; i++) begin
        if (c[i]) begin
          n_checks++;
          if (dout[i] !== mem_word(sd_addr_of(i, na[i]))) begin
            n_fail++; $display("FAIL rnd_dout round=%0d slot=%0d got=%h exp=%h", r, i, dout[i], mem_word(sd_addr_of(i, na[i])));
          end
        end else begin
          n_checks++; if (ok[i] !== 1'b0) begin n_fail++; $display("FAIL rnd_idle_ok round=%0d slot=%0d got=%b exp=0", r, i, ok[i]); end
        end
      end
    end
    rand_dly = 1'b0;
  endtask

  initial begin
    sd.sdram_ack = 1'b0;
    sd.data_rdy  = 1'b0;
    sd.data_read = '0;
    for (int i = 0; i < 3; i++) addr[i] = '0;
    test_reset;
    test_single_miss;
    test_repeated_hit;
    test_priority;
    test_flush;
    test_addr_change;
    test_timeout;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/jtgng_rom_fetch.md
Name: jtgng_rom_fetch

Overview:
- Game-side requester for the SDRAM read port: the agent that drives read_req/sdram_addr and consumes sdram_ack/data_rdy/data_read.
- Serves three ROM clients (slot0 = CPU, slot1 = char, slot2 = obj). Each slot has a one-word (32-bit) tagged cache.
- Misses are arbitrated onto the single SDRAM read port; refresh is permitted only when no miss is pending.
- Sits between the game core and the SDRAM controller, clocked on the same clk.

Parameters:
AW, 17, slot address width (32-bit word address within the slot region)
SLOT0_OFFSET, 22'h00_0000, SDRAM base for slot0
SLOT1_OFFSET, 22'h08_0000, SDRAM base for slot1
SLOT2_OFFSET, 22'h10_0000, SDRAM base for slot2
TIMEOUT, 64, cycles allowed from ack to data_rdy before a retry

Ports:
clk  in  1  system clock, same as SDRAM controller
rst  in  1  reset
downloading  in  1  ROM load in progress; flushes caches and blocks requests
slotN_cs (N=0..2)  in  1  slot N wants data
slotN_addr  in  AW  slot N word address
slotN_dout  out  32  slot N data
slotN_ok  out  1  slotN_dout is valid for the current slotN_addr
read_req  out  1  request to SDRAM controller
sdram_addr  out  22  SDRAM word address (offset + slot address)
sdram_ack  in  1  one-cycle request-accepted pulse
data_rdy  in  1  one-cycle pulse; data_read becomes valid on the following cycle
data_read  in  32  SDRAM read data
refresh_en  out  1  controller may issue autorefresh

Behaviour:
- Reset is rst, asynchronous, active-high; clock is clk. On reset:
  - read_req = 0, sdram_addr = 0, refresh_en = 0.
  - All slotN_ok = 0 and slotN_dout = 0.
  - All cache valid bits = 0. FSM = IDLE.
- Per-slot cache: valid bit, AW-bit tag, 32-bit data.
- hitN = slotN_cs & validN & (tagN == slotN_addr).
- slotN_ok is registered: slotN_ok <= hitN. It therefore rises 1 cycle after a hit condition.
- slotN_dout = cached data, updated only on fill.
- missN = slotN_cs & ~hitN & ~downloading.
- Fixed priority: slot0 > slot1 > slot2. The winner is sampled only in IDLE.
- FSM states:
  - IDLE: if any miss, latch slot index and address into the request tag. Set sdram_addr = SLOTn_OFFSET + zero-extended addr (22-bit, wrap modulo 2^22). Set read_req = 1. Go to REQ.
  - REQ: hold read_req and sdram_addr stable until sdram_ack. On sdram_ack: read_req <= 0, clear the timeout counter, go to WAIT.
  - WAIT: on data_rdy go to FILL. If the counter reaches TIMEOUT-1, go to IDLE with no fill; the miss persists and is re-requested.
  - FILL (exactly 1 cycle after data_rdy): write data_read into the slot selected by the latched index. Set tag = latched address, valid = 1. Go to IDLE.
- A slot address change while its request is in flight does not abort the request. The fill uses the latched tag, so the hit compare fails and a new request follows.
- refresh_en = 1 only when the FSM is IDLE, no missN is asserted, and downloading = 0. It is registered, reset 0.
- downloading = 1:
  - Clears all valid bits and forces slotN_ok = 0 next cycle.
  - Drops read_req and returns the FSM to IDLE from any state. Any in-flight data_rdy is ignored.
- Simultaneous events:
  - Fill and hit on the same slot in one cycle: the hit evaluates against pre-fill contents.
  - A fill for slot A does not affect slots B and C.
- Throughput: one outstanding request max. Minimum miss-to-ok latency = 1 (IDLE) + ack wait + data wait + 1 (FILL) + 1 (ok register).

Test Plan:
- Single miss: slot0_cs = 1, addr = 17'h00010; controller model acks 2 cycles after read_req and pulses data_rdy 3 cycles later, with data_read = 32'hDEADBEEF the next cycle -> sdram_addr = 22'h000010, one request, slot0_dout = 32'hDEADBEEF, slot0_ok = 1 two cycles after data_rdy.
- Repeated hit: keep slot0 addr = 17'h00010 for 100 cycles after the fill -> no further read_req, slot0_ok stays 1, refresh_en = 1.
- Priority: slot1 (addr 5) and slot2 (addr 7) miss together -> first sdram_addr = 22'h080005, then 22'h100007. If slot0 misses while slot1 is in flight, slot0 is served before slot2.
- Address change in flight: slot2 addr changes from 7 to 8 between ack and data_rdy -> fill writes tag 7, slot2_ok stays 0, next sdram_addr = 22'h100008.
- Timeout: acknowledge but never pulse data_rdy -> read_req reasserts TIMEOUT+1 cycles after ack with the same address.
- Download flush: cached hits on all slots, then downloading = 1 for 10 cycles -> all ok = 0 next cycle, read_req = 0, refresh_en = 0. After deassert, every slot re-fetches.
